// File: rtl/nes_palette_pkg.sv
// nes_palette_pkg
//   Shared constants, FSM state type and the backdrop mirror map for the
//   NES palette RAM.
//   Contents:
//     PAL_ADDR_W / PAL_DATA_W : default palette geometry (32 x 8)
//     GRAY_MASK               : colour-index bits that survive grayscale
//     pal_state_e             : init/run FSM states
//     mirror_addr()           : effective-address function
package nes_palette_pkg;

    localparam int PAL_ADDR_W = 5;
    localparam int PAL_DATA_W = 8;

    // Grayscale keeps only the luma bits [5:4] of the 6-bit colour index.
    localparam logic [PAL_DATA_W-1:0] GRAY_MASK = 8'h30;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } pal_state_e;

    // Sprite backdrop slots 0x10/0x14/0x18/0x1C alias the background
    // slots 0x00/0x04/0x08/0x0C. Width-agnostic so any ADDR_W can use it.
    function automatic logic [31:0] mirror_addr(input logic [31:0] a,
                                                input logic        en);
        logic [31:0] r;
        r = a;
        if (en && (a[1:0] == 2'b00)) begin
            r[4] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/nes_palette_init_rom.sv
// nes_palette_init_rom
//   Combinational power-on default palette. Entries above 0x1F repeat the
//   32-entry table.
//   Ports:
//     addr : table index
//     data : default entry, zero-extended/truncated to DATA_W
module nes_palette_init_rom
    import nes_palette_pkg::*;
#(
    parameter int ADDR_W = PAL_ADDR_W,
    parameter int DATA_W = PAL_DATA_W
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic [7:0] val;

    // Backdrop aliases (0x10/0x14/0x18/0x1C) hold the same value as their
    // targets, because the init pass writes them last over 0x00/0x04/...
    always_comb begin
        val = 8'h0F;
        case (addr[4:0])
            5'h00: val = 8'h22;
            5'h01: val = 8'h29;
            5'h02: val = 8'h1A;
            5'h03: val = 8'h0F;
            5'h04: val = 8'h22;
            5'h05: val = 8'h36;
            5'h06: val = 8'h17;
            5'h07: val = 8'h0F;
            5'h08: val = 8'h22;
            5'h09: val = 8'h30;
            5'h0A: val = 8'h21;
            5'h0B: val = 8'h0F;
            5'h0C: val = 8'h22;
            5'h0D: val = 8'h27;
            5'h0E: val = 8'h17;
            5'h0F: val = 8'h0F;
            5'h10: val = 8'h22;
            5'h11: val = 8'h16;
            5'h12: val = 8'h27;
            5'h13: val = 8'h18;
            5'h14: val = 8'h22;
            5'h15: val = 8'h1A;
            5'h16: val = 8'h30;
            5'h17: val = 8'h27;
            5'h18: val = 8'h22;
            5'h19: val = 8'h16;
            5'h1A: val = 8'h30;
            5'h1B: val = 8'h27;
            5'h1C: val = 8'h22;
            5'h1D: val = 8'h0F;
            5'h1E: val = 8'h36;
            5'h1F: val = 8'h17;
            default: val = 8'h0F;
        endcase
        data = DATA_W'(val);
    end

endmodule

// File: rtl/nes_palette_ram.sv
// nes_palette_ram
//   Writable palette memory. After reset an FSM copies the default table
//   into storage (one entry per cycle), then CPU writes are accepted every
//   cycle. NUM_RD registered read ports with write-first bypass; port 0
//   optionally returns grayscale.
//   Ports:
//     clk, rst   : clock, async active-high reset
//     wr_en/wr_addr/wr_data/wr_rdy : CPU write port
//     rd_addr    : packed read addresses, port k in slice k
//     rd_data    : packed registered read data, port k in slice k
//     gray       : grayscale on port 0
//     init_busy  : defaults still loading, rd_data not yet valid
//   Handshake: a write happens on a rising edge where wr_en & wr_rdy;
//   with wr_rdy low the request is dropped, never queued.
module nes_palette_ram
    import nes_palette_pkg::*;
#(
    parameter int ADDR_W = PAL_ADDR_W,
    parameter int DATA_W = PAL_DATA_W,
    parameter int NUM_RD = 2,
    parameter int MIRROR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_rdy,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     gray,
    output logic                     init_busy
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    // Grayscale clears the hue nibble [3:0] and leaves every other bit.
    localparam logic [DATA_W-1:0] GRAY_KEEP = ~DATA_W'(4'hF);

    function automatic logic [ADDR_W-1:0] eff(input logic [ADDR_W-1:0] a);
        return ADDR_W'(mirror_addr(32'(a), MIRROR != 0));
    endfunction

    // ---------------- FSM + init counter ----------------
    pal_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rom_data;

    nes_palette_init_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_init_rom (
        .addr (cnt_q),
        .data (rom_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_busy = (state_q == INIT);
    assign wr_rdy    = (state_q == RUN);

    // ---------------- single write port (init or CPU) ----------------
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    always_comb begin
        we = 1'b0;
        wa = eff(wr_addr);
        wd = wr_data;
        if (init_busy) begin
            we = 1'b1;
            wa = eff(cnt_q);
            wd = rom_data;
        end else begin
            we = wr_en;
        end
    end

    // Storage is intentionally not reset; the init pass defines it.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wa] <= wd;
        end
    end

    // ---------------- read ports ----------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] raw;
        logic [DATA_W-1:0] rd_d, rd_q;

        assign ra  = eff(rd_addr[k*ADDR_W +: ADDR_W]);
        // Write-first: a same-cycle write to this entry wins over storage.
        assign raw = (we && (wa == ra)) ? wd : mem_q[ra];

        if (k == 0) begin : g_gray
            assign rd_d = gray ? (raw & GRAY_KEEP) : raw;
        end else begin : g_plain
            assign rd_d = raw;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rd_q;
    end

endmodule
